// File: rtl/axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axi_sram_slave                                             |
// | Description : Single-beat AXI4 slave in front of a 32-bit word array.    |
// |               One transaction in flight, programmable R/B latency,       |
// |               DECERR outside the mapped window, SLVERR on bursts.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axi_sram_slave #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_awready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  output logic        io_slave_wready,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  output logic        io_slave_arready,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] C_RD_LAT = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] C_WR_LAT = CNT_W'(WR_LAT);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [1:0] C_OKAY   = 2'b00;
  localparam logic [1:0] C_SLVERR = 2'b10;
  localparam logic [1:0] C_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_DATA = 3'd3,
    WR_WAIT = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [1:0]              err_q, err_d;
  logic [3:0]              id_q, id_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [3:0]              bid_q, bid_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rlast_q, rlast_d;
  logic [3:0]              rid_q, rid_d;
  logic [31:0]             mem_q [2**DEPTH_LOG2];

  // In IDLE the write channel wins, so decode whichever address is about to be taken
  logic [31:0]           w_hs_addr, w_offset;
  logic [7:0]            w_hs_len;
  logic [1:0]            w_hs_err;
  logic [DEPTH_LOG2-1:0] w_hs_idx;
  assign w_hs_addr = io_slave_awvalid ? io_slave_awaddr : io_slave_araddr;
  assign w_hs_len  = io_slave_awvalid ? io_slave_awlen  : io_slave_arlen;
  assign w_offset  = w_hs_addr - BASE;
  assign w_hs_idx  = w_offset[DEPTH_LOG2+1:2];
  assign w_hs_err  = (|w_offset[31:DEPTH_LOG2+2]) ? C_DECERR :
                     (w_hs_len != 8'd0)           ? C_SLVERR : C_OKAY;

  // A zero-latency read samples the live request; otherwise the latched one
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [1:0]            w_rd_err;
  logic [3:0]            w_rd_id;
  assign w_rd_idx = (state_q == IDLE) ? w_hs_idx      : idx_q;
  assign w_rd_err = (state_q == IDLE) ? w_hs_err      : err_q;
  assign w_rd_id  = (state_q == IDLE) ? io_slave_arid : id_q;

  logic w_enter_rd, w_enter_wr;
  assign w_enter_rd = (state_q == IDLE && !io_slave_awvalid && io_slave_arvalid && RD_LAT == 0) ||
                      (state_q == RD_WAIT && cnt_q == C_ONE);
  assign w_enter_wr = (state_q == WR_DATA && io_slave_wvalid && WR_LAT == 0) ||
                      (state_q == WR_WAIT && cnt_q == C_ONE);

  // With zero write latency the beat goes to the array straight from the bus
  logic [31:0] w_cur_data, w_old, w_merged;
  logic [3:0]  w_cur_strb;
  logic        w_mem_we;
  assign w_cur_data = (state_q == WR_DATA) ? io_slave_wdata : wdata_q;
  assign w_cur_strb = (state_q == WR_DATA) ? io_slave_wstrb : wstrb_q;
  assign w_old      = mem_q[idx_q];
  assign w_mem_we   = w_enter_wr && (err_q == C_OKAY) && !reset;

  // Byte-lane merge of the stored word with the write beat
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_cur_strb[i]) w_merged[8*i +: 8] = w_cur_data[8*i +: 8];
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    id_d     = id_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    case (state_q)
      IDLE: begin
        if (io_slave_awvalid) begin
          idx_d   = w_hs_idx;
          err_d   = w_hs_err;
          id_d    = io_slave_awid;
          state_d = WR_DATA;
        end else if (io_slave_arvalid) begin
          idx_d   = w_hs_idx;
          err_d   = w_hs_err;
          id_d    = io_slave_arid;
          cnt_d   = C_RD_LAT;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt_q != C_ONE) cnt_d = cnt_q - C_ONE;
      RD_RESP: begin
        if (io_slave_rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_DATA: begin
        if (io_slave_wvalid) begin
          wdata_d = io_slave_wdata;
          wstrb_d = io_slave_wstrb;
          cnt_d   = C_WR_LAT;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: if (cnt_q != C_ONE) cnt_d = cnt_q - C_ONE;
      WR_RESP: begin
        if (io_slave_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_enter_rd) begin
      state_d  = RD_RESP;
      rvalid_d = 1'b1;
      rlast_d  = 1'b1;
      rresp_d  = w_rd_err;
      rdata_d  = (w_rd_err == C_OKAY) ? mem_q[w_rd_idx] : 32'd0;
      rid_d    = w_rd_id;
    end
    if (w_enter_wr) begin
      state_d  = WR_RESP;
      bvalid_d = 1'b1;
      bresp_d  = err_q;
      bid_d    = id_q;
    end
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      err_q    <= C_OKAY;
      id_q     <= 4'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      cnt_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= C_OKAY;
      bid_q    <= 4'd0;
      rvalid_q <= 1'b0;
      rresp_q  <= C_OKAY;
      rdata_q  <= 32'd0;
      rlast_q  <= 1'b0;
      rid_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      id_q     <= id_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cnt_q    <= cnt_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      rlast_q  <= rlast_d;
      rid_q    <= rid_d;
    end
  end

  // Array commit, once, on the edge that enters WR_RESP; contents survive reset
  always_ff @(posedge clock) begin
    if (w_mem_we) mem_q[idx_q] <= w_merged;
  end

  assign io_slave_awready = (state_q == IDLE);
  assign io_slave_arready = (state_q == IDLE) && !io_slave_awvalid;
  assign io_slave_wready  = (state_q == WR_DATA);
  assign io_slave_bvalid  = bvalid_q;
  assign io_slave_bresp   = bresp_q;
  assign io_slave_bid     = bid_q;
  assign io_slave_rvalid  = rvalid_q;
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rdata   = rdata_q;
  assign io_slave_rlast   = rlast_q;
  assign io_slave_rid     = rid_q;

  // Size, burst type, wlast and the byte offset do not affect a single-word access
  logic w_unused;
  assign w_unused = ^{io_slave_awsize, io_slave_awburst, io_slave_wlast,
                      io_slave_arsize, io_slave_arburst, w_offset[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axi_sram_slave                                          |
// | Description : Directed bench for axi_sram_slave at three latency setups. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axi_sram_slave;
  localparam int N = 3;
  localparam int RL [N] = '{2, 0, 2};
  localparam int WL [N] = '{1, 0, 4};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_s   [N];
  logic        awvalid [N];
  logic [31:0] awaddr  [N];
  logic [3:0]  awid    [N];
  logic [7:0]  awlen   [N];
  logic        awready [N];
  logic        wvalid  [N];
  logic [31:0] wdata   [N];
  logic [3:0]  wstrb   [N];
  logic        wready  [N];
  logic        bready  [N];
  logic        bvalid  [N];
  logic [1:0]  bresp   [N];
  logic [3:0]  bid     [N];
  logic        arvalid [N];
  logic [31:0] araddr  [N];
  logic [3:0]  arid    [N];
  logic [7:0]  arlen   [N];
  logic        arready [N];
  logic        rready  [N];
  logic        rvalid  [N];
  logic [1:0]  rresp   [N];
  logic [31:0] rdata   [N];
  logic        rlast   [N];
  logic [3:0]  rid     [N];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    axi_sram_slave #(
      .DEPTH_LOG2(12), .BASE(32'h8000_0000), .RD_LAT(RL[g]), .WR_LAT(WL[g])
    ) u_dut (
      .clock(clock), .reset(rst_s[g]),
      .io_slave_awvalid(awvalid[g]), .io_slave_awaddr(awaddr[g]), .io_slave_awid(awid[g]),
      .io_slave_awlen(awlen[g]), .io_slave_awsize(3'd2), .io_slave_awburst(2'b01),
      .io_slave_awready(awready[g]),
      .io_slave_wvalid(wvalid[g]), .io_slave_wdata(wdata[g]), .io_slave_wstrb(wstrb[g]),
      .io_slave_wlast(1'b1), .io_slave_wready(wready[g]),
      .io_slave_bready(bready[g]), .io_slave_bvalid(bvalid[g]), .io_slave_bresp(bresp[g]),
      .io_slave_bid(bid[g]),
      .io_slave_arvalid(arvalid[g]), .io_slave_araddr(araddr[g]), .io_slave_arid(arid[g]),
      .io_slave_arlen(arlen[g]), .io_slave_arsize(3'd2), .io_slave_arburst(2'b01),
      .io_slave_arready(arready[g]),
      .io_slave_rready(rready[g]), .io_slave_rvalid(rvalid[g]), .io_slave_rresp(rresp[g]),
      .io_slave_rdata(rdata[g]), .io_slave_rlast(rlast[g]), .io_slave_rid(rid[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic aw_hs(input string tag, input int k, input logic [31:0] a,
                       input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    awvalid[k] = 1'b1; awaddr[k] = a; awid[k] = id; awlen[k] = len;
    while (awready[k] !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk({tag, ".awready"}, 32'(awready[k]), 32'd1);
    @(posedge clock); @(negedge clock);
    awvalid[k] = 1'b0;
  endtask

  task automatic w_hs(input string tag, input int k, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wvalid[k] = 1'b1; wdata[k] = d; wstrb[k] = s;
    while (wready[k] !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk({tag, ".wready"}, 32'(wready[k]), 32'd1);
    @(posedge clock); @(negedge clock);
    wvalid[k] = 1'b0;
  endtask

  // Full write; lat counts edges from the W handshake to the first edge seeing bvalid
  task automatic wr(input string tag, input int k, input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input int el);
    int n = 0;
    aw_hs(tag, k, a, id, len);
    w_hs(tag, k, d, s);
    while (bvalid[k] !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk({tag, ".bvalid"}, 32'(bvalid[k]), 32'd1);
    chk({tag, ".blat"}, n + 1, el);
    chk({tag, ".bresp"}, 32'(bresp[k]), 32'(er));
    chk({tag, ".bid"}, 32'(bid[k]), 32'(id));
    bready[k] = 1'b1;
    @(posedge clock); @(negedge clock);
    bready[k] = 1'b0;
    chk({tag, ".bdrop"}, 32'(bvalid[k]), 32'd0);
  endtask

  // Full read with rready withheld for `hold` cycles once rvalid is up
  task automatic rd(input string tag, input int k, input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input int hold, input logic [31:0] ed,
                    input logic [1:0] er, input int el);
    int n = 0;
    arvalid[k] = 1'b1; araddr[k] = a; arid[k] = id; arlen[k] = len;
    while (arready[k] !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk({tag, ".arready"}, 32'(arready[k]), 32'd1);
    @(posedge clock); @(negedge clock);
    arvalid[k] = 1'b0;
    n = 0;
    while (rvalid[k] !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk({tag, ".rvalid"}, 32'(rvalid[k]), 32'd1);
    chk({tag, ".rlat"}, n + 1, el);
    chk({tag, ".rdata"}, rdata[k], ed);
    chk({tag, ".rresp"}, 32'(rresp[k]), 32'(er));
    chk({tag, ".rid"}, 32'(rid[k]), 32'(id));
    chk({tag, ".rlast"}, 32'(rlast[k]), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk({tag, ".hold_rvalid"}, 32'(rvalid[k]), 32'd1);
      chk({tag, ".hold_rdata"}, rdata[k], ed);
      chk({tag, ".hold_rresp"}, 32'(rresp[k]), 32'(er));
    end
    rready[k] = 1'b1;
    @(posedge clock); @(negedge clock);
    rready[k] = 1'b0;
    chk({tag, ".rdrop"}, 32'(rvalid[k]), 32'd0);
    chk({tag, ".idle"}, 32'(awready[k]), 32'd1);
  endtask

  // AW and AR together in IDLE: write must complete before the read is taken
  task automatic collision(input string tag, input int k, input logic [31:0] a,
                           input logic [31:0] d, input int wl, input int rl);
    arvalid[k] = 1'b1; araddr[k] = a; arid[k] = 4'd7; arlen[k] = 8'd0;
    awvalid[k] = 1'b1; awaddr[k] = a; awid[k] = 4'd6; awlen[k] = 8'd0;
    #1;
    chk({tag, ".arready_blocked"}, 32'(arready[k]), 32'd0);
    chk({tag, ".awready"}, 32'(awready[k]), 32'd1);
    wr(tag, k, a, 4'd6, 8'd0, d, 4'hF, 2'b00, wl);
    chk({tag, ".arready_after_b"}, 32'(arready[k]), 32'd1);
    chk({tag, ".no_early_r"}, 32'(rvalid[k]), 32'd0);
    rd(tag, k, a, 4'd7, 8'd0, 0, d, 2'b00, rl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    for (int k = 0; k < N; k++) begin
      rst_s[k] = 1'b1;
      awvalid[k] = 1'b0; awaddr[k] = '0; awid[k] = '0; awlen[k] = '0;
      wvalid[k] = 1'b0; wdata[k] = '0; wstrb[k] = '0; bready[k] = 1'b0;
      arvalid[k] = 1'b0; araddr[k] = '0; arid[k] = '0; arlen[k] = '0; rready[k] = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;

    // Reset state
    for (int k = 0; k < N; k++) begin
      chk("rst.bvalid", 32'(bvalid[k]), 32'd0);
      chk("rst.rvalid", 32'(rvalid[k]), 32'd0);
      chk("rst.rlast", 32'(rlast[k]), 32'd0);
      chk("rst.wready", 32'(wready[k]), 32'd0);
      chk("rst.bresp", 32'(bresp[k]), 32'd0);
      chk("rst.rresp", 32'(rresp[k]), 32'd0);
      chk("rst.rdata", rdata[k], 32'd0);
      chk("rst.bid", 32'(bid[k]), 32'd0);
      chk("rst.rid", 32'(rid[k]), 32'd0);
      chk("rst.awready", 32'(awready[k]), 32'd1);
      chk("rst.arready", 32'(arready[k]), 32'd1);
    end
    awvalid[0] = 1'b1; #1;
    chk("idle.arready_awvalid", 32'(arready[0]), 32'd0);
    awvalid[0] = 1'b0;
    wvalid[0] = 1'b1; #1;
    chk("idle.w_before_aw", 32'(wready[0]), 32'd0);
    wvalid[0] = 1'b0;
    @(negedge clock);

    // RD_LAT=2, WR_LAT=1
    wr("pre10", 0, 32'h8000_0040, 4'd1, 8'd0, 32'hDEAD_BEEF, 4'hF, 2'b00, 2);
    rd("rd10", 0, 32'h8000_0040, 4'd3, 8'd0, 0, 32'hDEAD_BEEF, 2'b00, 3);
    wr("part", 0, 32'h8000_0040, 4'd5, 8'd0, 32'h1122_3344, 4'b0101, 2'b00, 2);
    rd("part_rb", 0, 32'h8000_0040, 4'd3, 8'd0, 0, 32'hDE22_BE44, 2'b00, 3);
    rd("bp", 0, 32'h8000_0040, 4'd4, 8'd0, 5, 32'hDE22_BE44, 2'b00, 3);
    wr("pre0", 0, 32'h8000_0000, 4'd1, 8'd0, 32'h0BAD_F00D, 4'hF, 2'b00, 2);
    rd("oob_lo", 0, 32'h7FFF_FFFC, 4'd2, 8'd0, 0, 32'd0, 2'b11, 3);
    wr("oob_w", 0, 32'h8001_0000, 4'd6, 8'd0, 32'hFFFF_FFFF, 4'hF, 2'b11, 2);
    rd("oob_w_rb", 0, 32'h8000_0000, 4'd1, 8'd0, 0, 32'h0BAD_F00D, 2'b00, 3);
    wr("top", 0, 32'h8000_3FFC, 4'd2, 8'd0, 32'h1234_5678, 4'hF, 2'b00, 2);
    rd("top_rb", 0, 32'h8000_3FFC, 4'd2, 8'd0, 0, 32'h1234_5678, 2'b00, 3);
    rd("oob_hi", 0, 32'h8000_4000, 4'd2, 8'd0, 0, 32'd0, 2'b11, 3);
    rd("burst", 0, 32'h8000_0040, 4'd9, 8'd3, 0, 32'd0, 2'b10, 3);
    wr("wburst", 0, 32'h8000_0040, 4'd9, 8'd1, 32'hFFFF_FFFF, 4'hF, 2'b10, 2);
    rd("wburst_rb", 0, 32'h8000_0040, 4'd1, 8'd0, 0, 32'hDE22_BE44, 2'b00, 3);
    rd("prio", 0, 32'h7FFF_FFFC, 4'd8, 8'd3, 0, 32'd0, 2'b11, 3);
    collision("coll", 0, 32'h8000_0080, 32'h5566_7788, 2, 3);

    // RD_LAT=0, WR_LAT=0
    wr("z_wr", 1, 32'h8000_0008, 4'd1, 8'd0, 32'hA5A5_5A5A, 4'hF, 2'b00, 1);
    rd("z_rd", 1, 32'h8000_0008, 4'd2, 8'd0, 0, 32'hA5A5_5A5A, 2'b00, 1);
    collision("z_coll", 1, 32'h8000_0084, 32'h99AA_BBCC, 1, 1);

    // WR_LAT=4: reset two cycles after the W handshake
    wr("r_pre", 2, 32'h8000_0100, 4'd1, 8'd0, 32'hCAFE_F00D, 4'hF, 2'b00, 5);
    aw_hs("r_aw", 2, 32'h8000_0100, 4'd2, 8'd0);
    w_hs("r_w", 2, 32'h0000_0000, 4'hF);
    @(negedge clock);
    rst_s[2] = 1'b1;
    @(negedge clock);
    rst_s[2] = 1'b0;
    chk("r_rst.awready", 32'(awready[2]), 32'd1);
    chk("r_rst.wready", 32'(wready[2]), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bvalid[2] !== 1'b0) seen = 1'b1;
      @(negedge clock);
    end
    chk("r_rst.no_bvalid", 32'(seen), 32'd0);
    rd("r_rb", 2, 32'h8000_0100, 4'd3, 8'd0, 0, 32'hCAFE_F00D, 2'b00, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
